phys_reg_freelist: RTL

- Physical-register free pool for the rename stage of the 2-wide out-of-order RISC-V core.
- Supplies up to two free physical destination tags per cycle to rename, for instructions with RegWrite=1.
- Takes back up to two tags per cycle from retire. These are the old destinations of retiring instructions, carried on the regtofree_1/regtofree_2 path.
- Implemented as a circular FIFO of 7-bit tags. Order is strictly first-freed, first-reallocated.

---
 rtl/phys_reg_freelist.sv | 125 ++++++++++++
 1 files changed

// File: rtl/phys_reg_freelist.sv
// Physical-register free pool for a 2-wide rename stage: circular FIFO of tags, first-freed first-reallocated.
// Define FREELIST_CHECK_EN to add the in-pool tracking vector and the sticky dbl_free_err output.
module phys_reg_freelist #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int TAG_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req_1,
    input  logic             alloc_req_2,
    output logic [TAG_W-1:0] alloc_tag_1,
    output logic [TAG_W-1:0] alloc_tag_2,
    output logic             alloc_stall,
    input  logic             free_en_1,
    input  logic [TAG_W-1:0] free_tag_1,
    input  logic             free_en_2,
    input  logic [TAG_W-1:0] free_tag_2,
    output logic [TAG_W-1:0] free_count,
`ifdef FREELIST_CHECK_EN
    output logic             empty,
    output logic             dbl_free_err
`else
    output logic             empty
`endif
);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] headPtr, tailPtr;
    logic [PTR_W-1:0] headNext1, tailNext1;
    logic [1:0]       nReq, grantN, nFree;
    logic             grant;
    logic             valid1, valid2, ok1, ok2, acc1, acc2;
    logic [TAG_W:0]   countWide;
    logic [TAG_W-1:0] countNext;

    // DEPTH is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREGS-1:0] inPool;
    logic                 dupErr;
`endif

    always_comb begin
        headNext1   = ptrInc(headPtr);
        tailNext1   = ptrInc(tailPtr);
        nReq        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        alloc_stall = TAG_W'(nReq) > free_count;
        grant       = (nReq != 2'd0) && !alloc_stall;
        grantN      = grant ? nReq : 2'd0;
        alloc_tag_1 = entries[headPtr];
        // A lone lane-2 request takes the head entry; otherwise lane 2 shows head+1.
        alloc_tag_2 = (alloc_req_2 && !alloc_req_1) ? entries[headPtr] : entries[headNext1];

        valid1 = free_en_1 && (free_tag_1 != '0);
        valid2 = free_en_2 && (free_tag_2 != '0);
`ifdef FREELIST_CHECK_EN
        ok1    = valid1 && !inPool[free_tag_1];
        ok2    = valid2 && !inPool[free_tag_2] && !(valid1 && (free_tag_2 == free_tag_1));
        dupErr = (valid1 && !ok1) || (valid2 && !ok2);
`else
        ok1    = valid1;
        ok2    = valid2;
`endif
        // Overflow only happens on a retire bug: drop lane 2 first, then lane 1.
        countWide = {1'b0, free_count};
        acc1      = ok1 && (countWide < (TAG_W + 1)'(DEPTH));
        acc2      = ok2 && ((countWide + {{TAG_W{1'b0}}, acc1}) < (TAG_W + 1)'(DEPTH));
        nFree     = {1'b0, acc1} + {1'b0, acc2};
        countNext = free_count - TAG_W'(grantN) + TAG_W'(nFree);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= TAG_W'(NUM_AREGS + i);
            end
            headPtr    <= '0;
            tailPtr    <= '0;
            free_count <= TAG_W'(DEPTH);
            empty      <= 1'b0;
        end else begin
            if (acc1) begin
                entries[tailPtr] <= free_tag_1;
            end
            if (acc2) begin
                entries[acc1 ? tailNext1 : tailPtr] <= free_tag_2;
            end
            case (nFree)
                2'd1:    tailPtr <= tailNext1;
                2'd2:    tailPtr <= ptrInc(tailNext1);
                default: tailPtr <= tailPtr;
            endcase
            case (grantN)
                2'd1:    headPtr <= headNext1;
                2'd2:    headPtr <= ptrInc(headNext1);
                default: headPtr <= headPtr;
            endcase
            free_count <= countNext;
            empty      <= (countNext == '0);
        end
    end

`ifdef FREELIST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inPool       <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            dbl_free_err <= 1'b0;
        end else begin
            // Clears on grant come first so a same-cycle push of that tag wins.
            if (grant && alloc_req_1) inPool[alloc_tag_1] <= 1'b0;
            if (grant && alloc_req_2) inPool[alloc_tag_2] <= 1'b0;
            if (acc1) inPool[free_tag_1] <= 1'b1;
            if (acc2) inPool[free_tag_2] <= 1'b1;
            if (dupErr) dbl_free_err <= 1'b1;
        end
    end
`endif

endmodule
